// File: rtl/jtag_instr_dr_ctrl.sv
// JTAG instruction register, BYPASS/IDCODE data registers and DR strobe routing.
// Sits behind the TAP state machine; TDO is launched on the falling edge of tck.
module jtag_instr_dr_ctrl #(
    parameter int unsigned         IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(4'h1),
    parameter logic [IR_WIDTH-1:0] INSTR_USER0  = IR_WIDTH'(4'h8),
    parameter logic [IR_WIDTH-1:0] INSTR_USER1  = IR_WIDTH'(4'h9),
    parameter logic [IR_WIDTH-1:0] INSTR_BYPASS = '1
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tap_reset,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic                tdi,
    input  logic [1:0]          user_tdo,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [IR_WIDTH-1:0] instr,
    output logic [1:0]          user_sel,
    output logic [1:0]          user_capture,
    output logic [1:0]          user_shift,
    output logic [1:0]          user_update
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic [IR_WIDTH-1:0] instr_q, instr_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_sr_q, idcode_sr_d;
    logic                tdo_q, tdo_d;
    logic                tdo_oe_q, tdo_oe_d;

    logic                op_all_ones;
    logic                sel_idcode;
    logic                sel_bypass;
    logic [1:0]          sel_user;
    logic                ir_active;
    logic                dr_capture;
    logic                dr_shift;
    logic                dr_update;

    // All-ones always decodes as BYPASS, even if a user opcode is configured to it.
    always_comb begin
        op_all_ones = &instr_q;
        sel_idcode  = !op_all_ones && (instr_q == INSTR_IDCODE);
        sel_user[0] = !op_all_ones && !sel_idcode && (instr_q == INSTR_USER0);
        sel_user[1] = !op_all_ones && !sel_idcode && !sel_user[0] && (instr_q == INSTR_USER1);
        sel_bypass  = !sel_idcode && (sel_user == 2'b00);
    end

    // Any IR strobe masks the DR strobes, user chains included.
    always_comb begin
        ir_active  = capture_ir | shift_ir | update_ir;
        dr_capture = capture_dr & ~ir_active;
        dr_shift   = shift_dr & ~ir_active;
        dr_update  = update_dr & ~ir_active;
    end

    always_comb begin
        ir_sr_d = ir_sr_q;
        instr_d = instr_q;
        if (capture_ir) begin
            ir_sr_d = IR_CAPTURE;
        end else if (shift_ir) begin
            ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
        end else if (update_ir) begin
            instr_d = ir_sr_q;
        end
        if (tap_reset) begin
            instr_d = INSTR_IDCODE;
        end
    end

    always_comb begin
        bypass_d    = bypass_q;
        idcode_sr_d = idcode_sr_q;
        if (sel_bypass) begin
            if (dr_capture) begin
                bypass_d = 1'b0;
            end else if (dr_shift) begin
                bypass_d = tdi;
            end
        end
        if (sel_idcode) begin
            if (dr_capture) begin
                idcode_sr_d = IDCODE_VAL;
            end else if (dr_shift) begin
                idcode_sr_d = {tdi, idcode_sr_q[31:1]};
            end
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_oe_d = 1'b0;
        if (shift_ir) begin
            tdo_d    = ir_sr_q[0];
            tdo_oe_d = 1'b1;
        end else if (dr_shift) begin
            tdo_oe_d = 1'b1;
            if (sel_idcode) begin
                tdo_d = idcode_sr_q[0];
            end else if (sel_user[0]) begin
                tdo_d = user_tdo[0];
            end else if (sel_user[1]) begin
                tdo_d = user_tdo[1];
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            instr_q     <= INSTR_IDCODE;
            ir_sr_q     <= IR_CAPTURE;
            bypass_q    <= 1'b0;
            idcode_sr_q <= IDCODE_VAL;
        end else begin
            instr_q     <= instr_d;
            ir_sr_q     <= ir_sr_d;
            bypass_q    <= bypass_d;
            idcode_sr_q <= idcode_sr_d;
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_oe_q <= tdo_oe_d;
        end
    end

    assign instr        = instr_q;
    assign user_sel     = sel_user;
    assign user_capture = dr_capture ? sel_user : 2'b00;
    assign user_shift   = dr_shift ? sel_user : 2'b00;
    assign user_update  = dr_update ? sel_user : 2'b00;
    assign tdo          = tdo_q;
    assign tdo_oe       = tdo_oe_q;

endmodule

// File: tb/tb_jtag_instr_dr_ctrl.sv
// Bench for jtag_instr_dr_ctrl: opcode table, directed corner sequences and random scans
// checked against a scan-level model (captured value followed by the shifted-in tdi stream).
module tb_jtag_instr_dr_ctrl;

    localparam int          IR_W    = 4;
    localparam logic [31:0] IDC     = 32'h1000_0001;
    localparam logic [3:0]  IR_CAPV = 4'b0001;

    localparam logic [5:0] CIR = 6'b000001;
    localparam logic [5:0] SIR = 6'b000010;
    localparam logic [5:0] UIR = 6'b000100;
    localparam logic [5:0] CDR = 6'b001000;
    localparam logic [5:0] SDR = 6'b010000;
    localparam logic [5:0] UDR = 6'b100000;
    localparam logic [5:0] NOP = 6'b000000;

    logic            tck = 1'b0;
    logic            trst = 1'b1;
    logic            tap_reset = 1'b0;
    logic            capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0;
    logic            capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0;
    logic            tdi = 1'b0;
    logic [1:0]      user_tdo = 2'b00;
    logic            tdo, tdo_oe;
    logic [IR_W-1:0] instr;
    logic [1:0]      user_sel, user_capture, user_shift, user_update;

    jtag_instr_dr_ctrl dut (
        .tck          (tck),
        .trst         (trst),
        .tap_reset    (tap_reset),
        .capture_ir   (capture_ir),
        .shift_ir     (shift_ir),
        .update_ir    (update_ir),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .tdi          (tdi),
        .user_tdo     (user_tdo),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe),
        .instr        (instr),
        .user_sel     (user_sel),
        .user_capture (user_capture),
        .user_shift   (user_shift),
        .user_update  (user_update)
    );

    always #5 tck = ~tck;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] model_instr;
    logic       s_tdo, s_oe;
    logic [1:0] s_ucap, s_ushift, s_uupd;
    logic [63:0] got;

    typedef struct {
        logic [3:0] op;
        logic [1:0] exp_sel;
        int         kind;   // 0 bypass, 1 idcode, 2 user0, 3 user1
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_sel(input logic [3:0] op);
        if (op == 4'h8) return 2'b01;
        if (op == 4'h9) return 2'b10;
        return 2'b00;
    endfunction

    // Called at posedge+1: drives one tck cycle, samples outputs after the negedge.
    task automatic step(input logic [5:0] strb, input logic t_di, input logic t_rst,
                        input logic [1:0] utdo);
        {update_dr, shift_dr, capture_dr, update_ir, shift_ir, capture_ir} = strb;
        tdi       = t_di;
        tap_reset = t_rst;
        user_tdo  = utdo;
        @(negedge tck);
        #1;
        s_tdo    = tdo;
        s_oe     = tdo_oe;
        s_ucap   = user_capture;
        s_ushift = user_shift;
        s_uupd   = user_update;
        @(posedge tck);
        #1;
        {update_dr, shift_dr, capture_dr, update_ir, shift_ir, capture_ir} = NOP;
        tdi       = 1'b0;
        tap_reset = 1'b0;
    endtask

    task automatic ir_scan(input logic [63:0] bits, input int n);
        logic [127:0] s;
        s = ({64'b0, bits} << IR_W) | 128'(IR_CAPV);
        step(CIR, 1'b0, 1'b0, 2'b00);
        check("ir_capture_oe", s_oe, 0);
        for (int i = 0; i < n; i++) begin
            step(SIR, bits[i], 1'b0, 2'b00);
            check("ir_tdo", s_tdo, s[i]);
            check("ir_oe", s_oe, 1);
        end
        step(UIR, 1'b0, 1'b0, 2'b00);
        check("ir_update_oe", s_oe, 0);
        model_instr = s[n +: 4];
        check("instr", instr, model_instr);
        check("user_sel", user_sel, exp_sel(model_instr));
    endtask

    task automatic dr_scan(input logic [63:0] bits, input int n);
        logic [127:0] s;
        logic [1:0]   sel;
        logic [1:0]   ut;
        logic         exp_b;
        sel = exp_sel(model_instr);
        if (model_instr == 4'h1) s = ({64'b0, bits} << 32) | 128'(IDC);
        else                     s = ({64'b0, bits} << 1);
        got = '0;
        step(CDR, 1'b0, 1'b0, 2'b00);
        check("dr_capture_oe", s_oe, 0);
        check("user_capture", s_ucap, sel);
        for (int i = 0; i < n; i++) begin
            ut = 2'($urandom_range(0, 3));
            step(SDR, bits[i], 1'b0, ut);
            if (sel == 2'b01)      exp_b = ut[0];
            else if (sel == 2'b10) exp_b = ut[1];
            else                   exp_b = s[i];
            got[i] = s_tdo;
            check("dr_tdo", s_tdo, exp_b);
            check("dr_oe", s_oe, 1);
            check("user_shift", s_ushift, sel);
        end
        step(UDR, 1'b0, 1'b0, 2'b00);
        check("dr_update_oe", s_oe, 0);
        check("user_update", s_uupd, sel);
    endtask

    initial begin
        tbl[0] = '{4'h1, 2'b00, 1};
        tbl[1] = '{4'h8, 2'b01, 2};
        tbl[2] = '{4'h9, 2'b10, 3};
        tbl[3] = '{4'hF, 2'b00, 0};
        tbl[4] = '{4'h5, 2'b00, 0};
        tbl[5] = '{4'h0, 2'b00, 0};
        tbl[6] = '{4'h2, 2'b00, 0};
        tbl[7] = '{4'hE, 2'b00, 0};
        tbl[8] = '{4'hA, 2'b00, 0};

        // Reset state
        #1 trst = 1'b0;
        #1;
        check("rst_instr", instr, 4'h1);
        check("rst_tdo", tdo, 0);
        check("rst_oe", tdo_oe, 0);
        check("rst_user_sel", user_sel, 2'b00);
        model_instr = 4'h1;
        @(posedge tck);
        #1 trst = 1'b1;
        step(NOP, 1'b0, 1'b0, 2'b00);

        // IDCODE scan after reset
        dr_scan(64'h0, 32);
        check("idcode_word", got[31:0], 32'h1000_0001);

        // IR all-ones, then BYPASS delay
        ir_scan(64'hF, 4);
        check("bypass_instr", instr, 4'hF);
        dr_scan(64'b01101, 5);
        check("bypass_word", got[4:0], 5'b11010);

        // USER0 strobes and undefined opcode
        ir_scan(64'h8, 4);
        check("user0_sel", user_sel, 2'b01);
        dr_scan(64'h3, 6);
        ir_scan(64'h5, 4);
        dr_scan(64'b1101, 4);
        check("undef_word", got[3:0], 4'b1010);

        // tap_reset from USER1
        ir_scan(64'h9, 4);
        step(NOP, 1'b0, 1'b1, 2'b00);
        model_instr = 4'h1;
        check("tap_reset_instr", instr, 4'h1);
        check("tap_reset_sel", user_sel, 2'b00);
        dr_scan(64'h0, 32);
        check("tap_reset_idcode", got[31:0], IDC);

        // Simultaneous IR and DR strobes with a user chain selected
        ir_scan(64'h8, 4);
        step(CIR | CDR, 1'b0, 1'b0, 2'b11);
        check("illegal_ucap", s_ucap, 2'b00);
        step(SIR | SDR, 1'b1, 1'b0, 2'b00);
        check("illegal_ushift", s_ushift, 2'b00);
        check("illegal_tdo", s_tdo, 1);
        check("illegal_oe", s_oe, 1);
        step(UIR | UDR, 1'b0, 1'b0, 2'b00);
        check("illegal_uupd", s_uupd, 2'b00);
        check("illegal_instr", instr, 4'h8);
        model_instr = 4'h8;

        // Partial IR update loads what the shift register holds
        ir_scan(64'h1, 2);

        // trst mid-IDCODE shift
        ir_scan(64'h1, 4);
        step(CDR, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) step(SDR, 1'b1, 1'b0, 2'b00);
        shift_dr = 1'b1;
        check("pre_trst_oe", tdo_oe, 1);
        #2 trst = 1'b0;
        #1;
        check("trst_tdo", tdo, 0);
        check("trst_oe", tdo_oe, 0);
        check("trst_instr", instr, 4'h1);
        model_instr = 4'h1;
        @(posedge tck);
        #1;
        shift_dr = 1'b0;
        trst = 1'b1;
        step(SIR, 1'b0, 1'b0, 2'b00);
        check("rst_ir_bit0", s_tdo, 1);
        step(SIR, 1'b0, 1'b0, 2'b00);
        check("rst_ir_bit1", s_tdo, 0);
        got = '0;
        for (int i = 0; i < 32; i++) begin
            step(SDR, 1'b0, 1'b0, 2'b00);
            got[i] = s_tdo;
        end
        check("trst_idcode_noncap", got[31:0], IDC);
        dr_scan(64'h0, 32);
        check("trst_idcode_scan", got[31:0], IDC);

        // Opcode table
        for (int k = 0; k < 9; k++) begin
            logic [1:0] ut;
            logic       exp_b;
            ir_scan({60'b0, tbl[k].op}, 4);
            check("tbl_sel", user_sel, tbl[k].exp_sel);
            step(CDR, 1'b0, 1'b0, 2'b00);
            check("tbl_ucap", s_ucap, tbl[k].exp_sel);
            ut = 2'($urandom_range(0, 3));
            step(SDR, 1'b1, 1'b0, ut);
            case (tbl[k].kind)
                1:       exp_b = 1'b1;
                2:       exp_b = ut[0];
                3:       exp_b = ut[1];
                default: exp_b = 1'b0;
            endcase
            check("tbl_first_bit", s_tdo, exp_b);
            step(UDR, 1'b0, 1'b0, 2'b00);
        end

        // Random scans
        for (int r = 0; r < 40; r++) begin
            int         choose;
            logic [3:0] op;
            logic [63:0] bits;
            choose = $urandom_range(0, 4);
            bits   = {$urandom, $urandom};
            if (choose == 0) begin
                case ($urandom_range(0, 4))
                    0: op = 4'h1;
                    1: op = 4'h8;
                    2: op = 4'h9;
                    3: op = 4'hF;
                    default: op = 4'($urandom_range(0, 15));
                endcase
                ir_scan({60'b0, op}, 4);
            end else if (choose == 1) begin
                ir_scan(bits, $urandom_range(1, 7));
            end else if (choose == 2) begin
                step(NOP, 1'b0, 1'b1, 2'b00);
                model_instr = 4'h1;
                check("rand_tap_reset", instr, model_instr);
            end else begin
                dr_scan(bits, $urandom_range(1, 40));
            end
            if ($urandom_range(0, 1) == 1) step(NOP, 1'b0, 1'b0, 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
